// File: rtl/axi4_rd_burst_splitter.sv
// axi4_rd_burst_splitter
//   Splits any AXI4 read burst (FIXED/INCR/WRAP, arlen 0..255) into a series
//   of single-beat downstream reads. Each returned beat is re-issued upstream
//   with the latched ID and a correct rlast. Only one downstream read is in
//   flight, and only one upstream burst is accepted at a time.
//
//   Ports:
//     clock, reset          clock; synchronous active-low reset
//     s_ar*                 upstream read-address channel (burst in)
//     s_r*                  upstream read-data channel (burst out)
//     m_ar*                 downstream single-beat read address
//     m_r*                  downstream read data (rlast/rid not used)
//
//   Optional build macro RD_SPLIT_ERR_ABORT_EN:
//     The first beat with a non-OKAY downstream response is returned as
//     received. The rest of the burst is then answered locally with SLVERR
//     and zero data, and no further downstream reads are issued.
//     If the macro is not defined, every beat is fetched and its response
//     is forwarded.
module axi4_rd_burst_splitter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic [ID_W-1:0]   s_arid,
    input  logic [7:0]        s_arlen,
    input  logic [2:0]        s_arsize,
    input  logic [1:0]        s_arburst,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic [ID_W-1:0]   s_rid,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [ID_W-1:0]   m_arid,
    output logic [2:0]        m_arsize,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp
);
    localparam int         MAX_SIZE    = $clog2(DATA_W / 8);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, RESP, ERR} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;   // address of the current beat
        logic [ID_W-1:0]   id;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } req_t;

    state_t     state;
    req_t       req_q;
    logic [7:0] cnt;
`ifdef RD_SPLIT_ERR_ABORT_EN
    logic       abort_q;           // an earlier beat of this burst failed
`endif

    assign m_araddr = req_q.addr;
    assign m_arid   = req_q.id;
    assign m_arsize = req_q.size;
    assign s_rid    = req_q.id;

    // Requests that are answered locally with SLVERR.
    logic req_bad;
    always_comb begin
        req_bad = 1'b0;
        if (s_arburst == 2'b11)
            req_bad = 1'b1;
        if (int'(s_arsize) > MAX_SIZE)
            req_bad = 1'b1;
        if (s_arburst == BURST_WRAP && !(s_arlen == 8'd1 || s_arlen == 8'd3 ||
                                         s_arlen == 8'd7 || s_arlen == 8'd15))
            req_bad = 1'b1;
    end

    // Next beat address. For WRAP the window is (len+1) beats, which is a
    // power of two, so a mask splits the held high part from the wrapping low part.
    logic [ADDR_W-1:0] step, inc_addr, wrap_mask, next_addr;
    always_comb begin
        step      = ADDR_W'(1) << req_q.size;
        inc_addr  = req_q.addr + step;
        wrap_mask = ((ADDR_W'(req_q.len) + ADDR_W'(1)) << req_q.size) - ADDR_W'(1);
        case (req_q.burst)
            BURST_FIXED: next_addr = req_q.addr;
            BURST_WRAP:  next_addr = (req_q.addr & ~wrap_mask) | (inc_addr & wrap_mask);
            default:     next_addr = inc_addr;
        endcase
    end

    logic [7:0] cnt_next;
    logic       last;
    assign cnt_next = cnt + 8'd1;
    assign last     = (cnt == req_q.len);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            req_q     <= '0;
            cnt       <= '0;
            s_arready <= 1'b0;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rlast   <= 1'b0;
            s_rdata   <= '0;
            s_rresp   <= '0;
`ifdef RD_SPLIT_ERR_ABORT_EN
            abort_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    s_arready <= 1'b1;
                    if (s_arvalid && s_arready) begin
                        s_arready <= 1'b0;
                        req_q     <= '{addr: s_araddr, id: s_arid, len: s_arlen,
                                       size: s_arsize, burst: s_arburst};
                        cnt       <= '0;
`ifdef RD_SPLIT_ERR_ABORT_EN
                        abort_q   <= 1'b0;
`endif
                        if (req_bad) begin
                            state    <= ERR;
                            s_rvalid <= 1'b1;
                            s_rdata  <= '0;
                            s_rresp  <= RESP_SLVERR;
                            s_rlast  <= (s_arlen == 8'd0);
                        end else begin
                            state     <= ADDR;
                            m_arvalid <= 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (m_rvalid) begin
                        m_rready <= 1'b0;
                        s_rvalid <= 1'b1;
                        s_rdata  <= m_rdata;
                        s_rresp  <= m_rresp;
                        s_rlast  <= last;
`ifdef RD_SPLIT_ERR_ABORT_EN
                        abort_q  <= (m_rresp != 2'b00);
`endif
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (s_rready) begin
                        if (last) begin
                            s_rvalid  <= 1'b0;
                            s_rlast   <= 1'b0;
                            s_arready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            cnt <= cnt_next;
`ifdef RD_SPLIT_ERR_ABORT_EN
                            if (abort_q) begin
                                // Answer the remaining beats locally; s_rvalid stays high.
                                s_rdata <= '0;
                                s_rresp <= RESP_SLVERR;
                                s_rlast <= (cnt_next == req_q.len);
                                state   <= ERR;
                            end else
`endif
                            begin
                                s_rvalid   <= 1'b0;
                                req_q.addr <= next_addr;
                                m_arvalid  <= 1'b1;
                                state      <= ADDR;
                            end
                        end
                    end
                end
                ERR: begin
                    if (s_rready) begin
                        if (last) begin
                            s_rvalid  <= 1'b0;
                            s_rlast   <= 1'b0;
                            s_arready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            cnt     <= cnt_next;
                            s_rlast <= (cnt_next == req_q.len);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_rd_burst_splitter.sv
// Bench for axi4_rd_burst_splitter: table vectors, hand-written corner
// sequences (backpressure, error beats, reset in WAIT), then random bursts
// compared against a burst-level reference model. A single-beat memory
// model with configurable latency stands in for the downstream slave.
module tb_axi4_rd_burst_splitter;
    logic        clock = 1'b0;
    logic        reset;
    logic        s_arvalid, s_arready;
    logic [31:0] s_araddr;
    logic [3:0]  s_arid;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_rvalid, s_rready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic [3:0]  s_rid;
    logic        m_arvalid, m_arready;
    logic [31:0] m_araddr;
    logic [3:0]  m_arid;
    logic [2:0]  m_arsize;
    logic        m_rvalid, m_rready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;

    axi4_rd_burst_splitter #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
        .clock(clock), .reset(reset),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arid(m_arid), .m_arsize(m_arsize),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Memory contents and error map of the downstream slave.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction
    function automatic logic [1:0] mem_resp(input logic [31:0] a);
        if (a[15:8] == 8'hEE) return 2'b10;
        if (a[15:8] == 8'hEF) return 2'b11;
        return 2'b00;
    endfunction

    // Downstream slave: one read at a time, decisions taken 1 unit after the
    // falling edge so they are settled well before the next rising edge.
    logic [31:0] ar_log[$];
    int          arv_cycles = 0;
    int          lat_cfg = 0;
    bit          rand_lat = 0, rand_arready = 0, rand_rready = 0;

    initial begin : slave
        bit          have = 0, ar_pend = 0;
        logic [31:0] raddr = '0, pend_addr = '0;
        int          dly = 0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
        forever begin
            @(negedge clock); #1;
            if (!reset) begin
                have = 0; ar_pend = 0; m_arready = 1'b0; m_rvalid = 1'b0;
            end else begin
                if (m_arvalid) arv_cycles++;
                m_rvalid = 1'b0;
                m_rdata  = $urandom;
                m_rresp  = 2'($urandom);
                if (have) begin
                    if (dly > 0) dly--;
                    else begin
                        m_rvalid = 1'b1;
                        m_rdata  = mem_data(raddr);
                        m_rresp  = mem_resp(raddr);
                        if (m_rready) have = 0;
                    end
                end
                if (ar_pend) begin
                    chk("ar_hold_valid", 64'(m_arvalid), 64'd1);
                    chk("ar_hold_addr", 64'(m_araddr), 64'(pend_addr));
                end
                m_arready = 1'b0;
                ar_pend   = 0;
                if (m_arvalid && !have) begin
                    if (rand_arready && $urandom_range(0, 2) == 0) begin
                        ar_pend = 1; pend_addr = m_araddr;
                    end else begin
                        m_arready = 1'b1;
                        have      = 1;
                        raddr     = m_araddr;
                        dly       = rand_lat ? int'($urandom_range(0, 3)) : lat_cfg;
                        ar_log.push_back(m_araddr);
                    end
                end
            end
        end
    end

    // Reference model: expected downstream addresses and upstream beats of one burst.
    logic [31:0] exp_ar[$], exp_data[$];
    logic [1:0]  exp_resp[$];

    task automatic build_expected(input logic [31:0] a, input logic [7:0] len,
                                  input logic [2:0] size, input logic [1:0] burst);
        longint unsigned nb = longint'(len) + 1;
        longint unsigned stp = longint'(1) << size;
        longint unsigned au = longint'(a);
        longint unsigned win, base;
        logic [31:0] ba;
        bit bad, aborted = 0;
        bad = (burst == 2'b11) || (size > 3'd2) ||
              (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
        exp_ar.delete(); exp_data.delete(); exp_resp.delete();
        for (longint unsigned i = 0; i < nb; i++) begin
            if (bad || aborted) begin
                exp_data.push_back(32'h0);
                exp_resp.push_back(2'b10);
            end else begin
                if (burst == 2'b00) ba = a;
                else if (burst == 2'b01) ba = 32'(au + i * stp);
                else begin
                    win  = nb * stp;
                    base = (au / win) * win;
                    ba   = 32'(base + ((au - base) + i * stp) % win);
                end
                exp_ar.push_back(ba);
                exp_data.push_back(mem_data(ba));
                exp_resp.push_back(mem_resp(ba));
`ifdef RD_SPLIT_ERR_ABORT_EN
                if (mem_resp(ba) != 2'b00) aborted = 1;
`endif
            end
        end
    endtask

    logic [31:0] got_data[$];
    logic [1:0]  got_resp[$];
    logic        got_last[$];
    logic [3:0]  got_id[$];

    task automatic send_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        @(negedge clock);
        s_arvalid = 1'b1; s_araddr = a; s_arid = id; s_arlen = len;
        s_arsize = size; s_arburst = burst;
        while (!s_arready && n < 100) begin @(negedge clock); n++; end
        if (!s_arready) begin
            checks++; errors++;
            $display("FAIL ar_timeout: got s_arready=0 after %0d cycles, required 1", n);
        end
        @(negedge clock);
        s_arvalid = 1'b0;
    endtask

    // Accepts nb beats. Beat number stall_beat is held off for 5 cycles.
    task automatic collect(input int nb, input int stall_beat);
        int got = 0, stall_left = 5, cyc = 0;
        bit pend = 0, r;
        logic [31:0] pd; logic [1:0] pr; logic pl; logic [3:0] pi;
        got_data.delete(); got_resp.delete(); got_last.delete(); got_id.delete();
        while (got < nb && cyc < 3000) begin
            @(negedge clock); cyc++;
            chk("arready_busy", 64'(s_arready), 64'd0);
            if (pend) begin
                chk("stall_valid", 64'(s_rvalid), 64'd1);
                chk("stall_data", 64'(s_rdata), 64'(pd));
                chk("stall_resp", 64'(s_rresp), 64'(pr));
                chk("stall_last", 64'(s_rlast), 64'(pl));
                chk("stall_id", 64'(s_rid), 64'(pi));
                chk("stall_no_m_ar", 64'(m_arvalid), 64'd0);
            end
            if (got == stall_beat && s_rvalid && stall_left > 0) begin
                r = 0; stall_left--;
            end else r = rand_rready ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_rready = r;
            pend = s_rvalid && !r;
            pd = s_rdata; pr = s_rresp; pl = s_rlast; pi = s_rid;
            if (s_rvalid && r) begin
                got_data.push_back(s_rdata); got_resp.push_back(s_rresp);
                got_last.push_back(s_rlast); got_id.push_back(s_rid);
                got++;
            end
        end
        if (got < nb) begin
            checks++; errors++;
            $display("FAIL beat_timeout: got %0d beats, required %0d", got, nb);
        end
    endtask

    task automatic run_txn(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int stall_beat);
        build_expected(a, len, size, burst);
        ar_log.delete();
        arv_cycles = 0;
        send_ar(a, id, len, size, burst);
        collect(int'(len) + 1, stall_beat);
        @(negedge clock);
        s_rready = 1'b0;
        chk("idle_rvalid", 64'(s_rvalid), 64'd0);
        chk("idle_arready", 64'(s_arready), 64'd1);
        chk("m_ar_count", 64'(ar_log.size()), 64'(exp_ar.size()));
        for (int i = 0; i < ar_log.size() && i < exp_ar.size(); i++)
            chk($sformatf("m_araddr[%0d]", i), 64'(ar_log[i]), 64'(exp_ar[i]));
        if (exp_ar.size() == 0) chk("no_m_arvalid", 64'(arv_cycles), 64'd0);
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            chk($sformatf("rdata[%0d]", i), 64'(got_data[i]), 64'(exp_data[i]));
            chk($sformatf("rresp[%0d]", i), 64'(got_resp[i]), 64'(exp_resp[i]));
            chk($sformatf("rlast[%0d]", i), 64'(got_last[i]), 64'(i == int'(len)));
            chk($sformatf("rid[%0d]", i), 64'(got_id[i]), 64'(id));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_arready"}, 64'(s_arready), 64'd0);
        chk({tag, "_s_rvalid"}, 64'(s_rvalid), 64'd0);
        chk({tag, "_m_arvalid"}, 64'(m_arvalid), 64'd0);
        chk({tag, "_m_rready"}, 64'(m_rready), 64'd0);
        chk({tag, "_s_rdata"}, 64'(s_rdata), 64'd0);
        chk({tag, "_s_rid"}, 64'(s_rid), 64'd0);
        chk({tag, "_m_araddr"}, 64'(m_araddr), 64'd0);
    endtask

    typedef struct {
        logic [31:0] addr; logic [3:0] id; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
        int nar; logic [31:0] ar0, ar1, ar2, ar3; int nbeats; logic [1:0] resp;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst, input int nar,
                                input logic [31:0] ar0, input logic [31:0] ar1,
                                input logic [31:0] ar2, input logic [31:0] ar3,
                                input int nbeats, input logic [1:0] resp);
        vec_t v;
        v.addr = addr; v.id = id; v.len = len; v.size = size; v.burst = burst; v.nar = nar;
        v.ar0 = ar0; v.ar1 = ar1; v.ar2 = ar2; v.ar3 = ar3; v.nbeats = nbeats; v.resp = resp;
        return v;
    endfunction

    vec_t vt[9];

    initial begin
        logic [31:0] ra; logic [7:0] rl; logic [2:0] rs; logic [1:0] rb;
        int sb, n;
        vt[0] = mk(32'h8000_0000, 4'h5, 8'd0, 3'd2, 2'b01, 1, 32'h8000_0000, 0, 0, 0, 1, 2'b00);
        vt[1] = mk(32'h8000_0000, 4'h3, 8'd3, 3'd2, 2'b01, 4, 32'h8000_0000, 32'h8000_0004,
                   32'h8000_0008, 32'h8000_000C, 4, 2'b00);
        vt[2] = mk(32'h8000_0008, 4'h9, 8'd3, 3'd2, 2'b10, 4, 32'h8000_0008, 32'h8000_000C,
                   32'h8000_0000, 32'h8000_0004, 4, 2'b00);
        vt[3] = mk(32'h8000_0010, 4'h1, 8'd2, 3'd2, 2'b00, 3, 32'h8000_0010, 32'h8000_0010,
                   32'h8000_0010, 0, 3, 2'b00);
        vt[4] = mk(32'h8000_0020, 4'h2, 8'd1, 3'd2, 2'b11, 0, 0, 0, 0, 0, 2, 2'b10);
        vt[5] = mk(32'h8000_0020, 4'h6, 8'd0, 3'd3, 2'b01, 0, 0, 0, 0, 0, 1, 2'b10);
        vt[6] = mk(32'h8000_0020, 4'hA, 8'd2, 3'd2, 2'b10, 0, 0, 0, 0, 0, 3, 2'b10);
        vt[7] = mk(32'hFFFF_FFFC, 4'hF, 8'd1, 3'd2, 2'b01, 2, 32'hFFFF_FFFC, 32'h0000_0000,
                   0, 0, 2, 2'b00);
        vt[8] = mk(32'h8000_0003, 4'h4, 8'd2, 3'd0, 2'b01, 3, 32'h8000_0003, 32'h8000_0004,
                   32'h8000_0005, 0, 3, 2'b00);

        reset = 1'b0; s_arvalid = 1'b0; s_araddr = '0; s_arid = '0; s_arlen = '0;
        s_arsize = '0; s_arburst = '0; s_rready = 1'b0;
        repeat (3) @(negedge clock);
        chk_reset_outputs("por");
        reset = 1'b1;
        @(negedge clock);
        chk("por_release_arready", 64'(s_arready), 64'd1);

        for (int i = 0; i < 9; i++) begin
            lat_cfg = i % 3;
            run_txn(vt[i].addr, vt[i].id, vt[i].len, vt[i].size, vt[i].burst, -1);
            chk($sformatf("tbl%0d_nar", i), 64'(ar_log.size()), 64'(vt[i].nar));
            if (vt[i].nar > 0 && ar_log.size() > 0) chk($sformatf("tbl%0d_ar0", i), 64'(ar_log[0]), 64'(vt[i].ar0));
            if (vt[i].nar > 1 && ar_log.size() > 1) chk($sformatf("tbl%0d_ar1", i), 64'(ar_log[1]), 64'(vt[i].ar1));
            if (vt[i].nar > 2 && ar_log.size() > 2) chk($sformatf("tbl%0d_ar2", i), 64'(ar_log[2]), 64'(vt[i].ar2));
            if (vt[i].nar > 3 && ar_log.size() > 3) chk($sformatf("tbl%0d_ar3", i), 64'(ar_log[3]), 64'(vt[i].ar3));
            chk($sformatf("tbl%0d_nbeats", i), 64'(got_data.size()), 64'(vt[i].nbeats));
            for (int b = 0; b < got_resp.size(); b++)
                chk($sformatf("tbl%0d_resp%0d", i, b), 64'(got_resp[b]), 64'(vt[i].resp));
        end

        // Backpressure on beat 2 of an INCR burst.
        lat_cfg = 1;
        run_txn(32'h8000_0040, 4'h7, 8'd3, 3'd2, 2'b01, 1);
        // Error arrives on beat 3 (0x8000EE00) and on beat 1, respectively.
        run_txn(32'h8000_EDF8, 4'hB, 8'd3, 3'd2, 2'b01, -1);
`ifdef RD_SPLIT_ERR_ABORT_EN
        chk("abort_mid_m_ar", 64'(ar_log.size()), 64'd3);
`endif
        run_txn(32'h8000_EE00, 4'hC, 8'd3, 3'd2, 2'b01, -1);
`ifdef RD_SPLIT_ERR_ABORT_EN
        chk("abort_first_m_ar", 64'(ar_log.size()), 64'd1);
`endif

        // Reset while waiting for beat 2 of 4.
        lat_cfg = 6;
        ar_log.delete();
        send_ar(32'h8000_0100, 4'h3, 8'd3, 3'd2, 2'b01);
        collect(1, -1);
        n = 0;
        do begin @(negedge clock); s_rready = 1'b0; n++; end while (!m_rready && n < 50);
        chk("rst_in_wait_m_rready", 64'(m_rready), 64'd1);
        chk("rst_in_wait_m_ar", 64'(ar_log.size()), 64'd2);
        reset = 1'b0;
        @(negedge clock); @(negedge clock);
        chk_reset_outputs("mid");
        reset = 1'b1;
        @(negedge clock);
        chk("mid_release_arready", 64'(s_arready), 64'd1);
        chk("mid_release_rvalid", 64'(s_rvalid), 64'd0);
        chk("mid_release_m_arvalid", 64'(m_arvalid), 64'd0);
        lat_cfg = 0;
        run_txn(32'h8000_0200, 4'h5, 8'd0, 3'd2, 2'b01, -1);

        // Random bursts with random latency and handshake throttling.
        rand_lat = 1; rand_arready = 1; rand_rready = 1;
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 3))
                0: ra = 32'h8000_0000 + $urandom_range(0, 1023);
                1: ra = 32'h8000_EE00 + $urandom_range(0, 255);
                2: ra = 32'hFFFF_FF00 + $urandom_range(0, 255);
                default: ra = $urandom;
            endcase
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0: rl = 8'd1;
                    1: rl = 8'd3;
                    2: rl = 8'd7;
                    default: rl = 8'd15;
                endcase
            end else rl = 8'($urandom_range(0, 9));
            rs = 3'($urandom_range(0, 3));
            rb = 2'($urandom_range(0, 3));
            sb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(rl))) : -1;
            run_txn(ra, 4'($urandom), rl, rs, rb, sb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
